// File: rtl/lcd_hd44780_pkg.sv
// rtl/lcd_hd44780_pkg.sv - HD44780 instruction classes, address constants and AC helpers
package lcd_hd44780_pkg;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam int         LINE_LEN   = 16;
  localparam logic [7:0] SPACE_CHAR = 8'h20;

  localparam logic [7:0] MASK_DDRAM = 8'h80, VAL_DDRAM = 8'h80;
  localparam logic [7:0] MASK_CGRAM = 8'hC0, VAL_CGRAM = 8'h40;
  localparam logic [7:0] MASK_FUNC  = 8'hE0, VAL_FUNC  = 8'h20;
  localparam logic [7:0] MASK_SHIFT = 8'hF0, VAL_SHIFT = 8'h10;
  localparam logic [7:0] MASK_DISP  = 8'hF8, VAL_DISP  = 8'h08;
  localparam logic [7:0] MASK_ENTRY = 8'hFC, VAL_ENTRY = 8'h04;
  localparam logic [7:0] MASK_HOME  = 8'hFE, VAL_HOME  = 8'h02;
  localparam logic [7:0] MASK_CLEAR = 8'hFF, VAL_CLEAR = 8'h01;

  typedef enum logic [3:0] {
    INS_NOP, INS_CLEAR, INS_HOME, INS_ENTRY, INS_DISP,
    INS_SHIFT, INS_FUNC, INS_CGRAM, INS_DDRAM
  } instr_e;

  function automatic instr_e instr_class(input logic [7:0] d);
    if      ((d & MASK_DDRAM) == VAL_DDRAM) return INS_DDRAM;
    else if ((d & MASK_CGRAM) == VAL_CGRAM) return INS_CGRAM;
    else if ((d & MASK_FUNC)  == VAL_FUNC)  return INS_FUNC;
    else if ((d & MASK_SHIFT) == VAL_SHIFT) return INS_SHIFT;
    else if ((d & MASK_DISP)  == VAL_DISP)  return INS_DISP;
    else if ((d & MASK_ENTRY) == VAL_ENTRY) return INS_ENTRY;
    else if ((d & MASK_HOME)  == VAL_HOME)  return INS_HOME;
    else if ((d & MASK_CLEAR) == VAL_CLEAR) return INS_CLEAR;
    else                                    return INS_NOP;
  endfunction

  function automatic logic ac_valid(input logic [6:0] a);
    return (a[5:4] == 2'b00);
  endfunction

  // Two 16-char lines live at 0x00-0x0F and 0x40-0x4F; stepping past either end hops lines.
  function automatic logic [6:0] ac_next(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == LINE1_BASE + 7'(LINE_LEN - 1)) return LINE2_BASE;
      if (a == LINE2_BASE + 7'(LINE_LEN - 1)) return LINE1_BASE;
      return a + 7'd1;
    end
    if (a == LINE2_BASE) return LINE1_BASE + 7'(LINE_LEN - 1);
    if (a == LINE1_BASE) return LINE2_BASE + 7'(LINE_LEN - 1);
    return a - 7'd1;
  endfunction

  function automatic logic [4:0] ac_slot(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction

endpackage

// File: rtl/lcd_en_sync.sv
// rtl/lcd_en_sync.sv - bus synchronizer, capture register and armed EN edge detector
module lcd_en_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rs,
  input  logic       rw,
  input  logic [7:0] data,
  output logic       rise,
  output logic       fall,
  output logic       bus_rs,
  output logic       bus_rw,
  output logic [7:0] bus_data
);

  logic [10:0] chain [SYNC_STAGES];
  logic [9:0]  cap;
  logic        en_s, en_prev, armed;

  assign en_s = chain[SYNC_STAGES-1][10];
  assign rise = en_s & ~en_prev;
  assign fall = ~en_s & en_prev & armed;
  // Live bus values while EN is high; the last captured values once it has dropped.
  assign {bus_rs, bus_rw, bus_data} = en_s ? chain[SYNC_STAGES-1][9:0] : cap;

  // EN resets to "high" so only a genuinely observed 0->1 counts as a rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= 11'h400;
      cap     <= '0;
      en_prev <= 1'b1;
      armed   <= 1'b0;
    end else begin
      chain[0] <= {en, rs, rw, data};
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      en_prev <= en_s;
      if (rise) armed <= 1'b1;
      if (en_s) cap <= chain[SYNC_STAGES-1][9:0];
    end
  end

endmodule

// File: rtl/lcd_hd44780_responder.sv
// rtl/lcd_hd44780_responder.sv - HD44780 display-side responder with 32-char DDRAM mirror
module lcd_hd44780_responder
  import lcd_hd44780_pkg::*;
#(
  parameter int BUSY_CYCLES      = 2000,
  parameter int BUSY_LONG_CYCLES = 82000,
  parameter int SYNC_STAGES      = 2
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       busy,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       cmd_err
);

  localparam int CW = $clog2(BUSY_LONG_CYCLES + 1);
  localparam logic [CW-1:0] SHORT_RELOAD = CW'(BUSY_CYCLES - 1);
  localparam logic [CW-1:0] LONG_RELOAD  = CW'(BUSY_LONG_CYCLES - 1);

  logic       rise, fall, bus_rs, bus_rw;
  logic [7:0] bus_data;
  logic [7:0] ddram [32];
  logic [6:0] ac;
  logic       inc;
  logic [CW-1:0] cnt;
  instr_e     cls;
  logic       wr_ok, start_busy, long_busy;

  lcd_en_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk_clk),
    .reset    (reset_reset),
    .en       (lcd_en),
    .rs       (lcd_rs),
    .rw       (lcd_rw),
    .data     (lcd_data_in),
    .rise     (rise),
    .fall     (fall),
    .bus_rs   (bus_rs),
    .bus_rw   (bus_rw),
    .bus_data (bus_data)
  );

  // A write landing on the last busy cycle (counter at zero) is accepted.
  always_comb begin
    cls        = instr_class(bus_data);
    wr_ok      = fall & ~bus_rw & ~(busy & (cnt != '0));
    start_busy = wr_ok & (bus_rs | (cls != INS_NOP));
    long_busy  = ~bus_rs & ((cls == INS_CLEAR) | (cls == INS_HOME));
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < 32; i++) ddram[i] <= SPACE_CHAR;
      ac           <= LINE1_BASE;
      inc          <= 1'b1;
      cnt          <= '0;
      busy         <= 1'b0;
      disp_on      <= 1'b0;
      cursor_on    <= 1'b0;
      blink_on     <= 1'b0;
      cmd_err      <= 1'b0;
      lcd_data_oe  <= 1'b0;
      lcd_data_out <= 8'h00;
      rd_char      <= SPACE_CHAR;
    end else begin
      rd_char <= ddram[rd_addr];

      if (busy) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else           busy <= 1'b0;
      end
      if (start_busy) begin
        busy <= 1'b1;
        cnt  <= long_busy ? LONG_RELOAD : SHORT_RELOAD;
      end

      if (rise && bus_rw) begin
        lcd_data_oe  <= 1'b1;
        lcd_data_out <= bus_rs ? ddram[ac_slot(ac)] : {busy, ac};
      end
      if (fall && bus_rw) begin
        lcd_data_oe <= 1'b0;
        if (bus_rs) ac <= ac_next(ac, inc);
      end

      if (fall && !bus_rw && !wr_ok) cmd_err <= 1'b1;

      if (wr_ok && bus_rs) begin
        ddram[ac_slot(ac)] <= bus_data;
        ac <= ac_next(ac, inc);
      end else if (wr_ok) begin
        case (cls)
          INS_DDRAM: begin
            if (ac_valid(bus_data[6:0])) ac <= bus_data[6:0];
            else begin
              ac      <= LINE1_BASE;
              cmd_err <= 1'b1;
            end
          end
          INS_SHIFT: if (!bus_data[3]) ac <= ac_next(ac, bus_data[2]);
          INS_DISP: begin
            disp_on   <= bus_data[2];
            cursor_on <= bus_data[1];
            blink_on  <= bus_data[0];
          end
          INS_ENTRY: inc <= bus_data[1];
          INS_HOME:  ac  <= LINE1_BASE;
          INS_CLEAR: begin
            for (int i = 0; i < 32; i++) ddram[i] <= SPACE_CHAR;
            ac  <= LINE1_BASE;
            inc <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// tb/tb_lcd_hd44780_responder.sv - scoreboard bench for the HD44780 responder
module tb_lcd_hd44780_responder;

  localparam int BUSY_CYCLES      = 40;
  localparam int BUSY_LONG_CYCLES = 300;

  logic       clk = 1'b0;
  logic       reset_reset, lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_data_in, lcd_data_out, rd_char;
  logic       lcd_data_oe, busy, disp_on, cursor_on, blink_on, cmd_err;
  logic [4:0] rd_addr;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  int   busy_run = 0, busy_len = 0;
  logic oe_prev = 1'b0;

  always #5 clk = ~clk;

  lcd_hd44780_responder #(
    .BUSY_CYCLES(BUSY_CYCLES), .BUSY_LONG_CYCLES(BUSY_LONG_CYCLES), .SYNC_STAGES(2)
  ) dut (
    .clk_clk(clk), .reset_reset(reset_reset), .lcd_en(lcd_en), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out),
    .lcd_data_oe(lcd_data_oe), .rd_addr(rd_addr), .rd_char(rd_char), .busy(busy),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on), .cmd_err(cmd_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Busy pulse length and read-response scoreboard.
  always @(negedge clk) begin
    if (reset_reset) begin
      busy_run = 0;
      oe_prev  = 1'b0;
    end else begin
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        busy_len = busy_run;
        busy_run = 0;
      end
      if (lcd_data_oe && !oe_prev) begin
        if (exp_q.size() == 0) check("read_unexpected", 32'(exp_q.size()), 32'd1);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check(e.tag, {24'h0, lcd_data_out}, {24'h0, e.val});
        end
      end
      oe_prev = lcd_data_oe;
    end
  end

  task automatic bus_cycle(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_en = 1'b1;
    repeat (6) @(negedge clk);
    lcd_en = 1'b0;
    repeat (6) @(negedge clk);
    lcd_rw = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("busy_timeout", {31'h0, busy}, 32'h0);
    @(negedge clk);
  endtask

  task automatic wr_idle(input logic rs, input logic [7:0] d);
    bus_cycle(rs, 1'b0, d);
    wait_idle();
  endtask

  task automatic rd(input logic rs, input logic [7:0] exp, input string tag);
    exp_t e;
    e.tag = tag;
    e.val = exp;
    exp_q.push_back(e);
    bus_cycle(rs, 1'b1, 8'h00);
    check({tag, "_done"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic slot(input int a, input logic [7:0] exp, input string tag);
    rd_addr = 5'(a);
    @(negedge clk);
    check(tag, {24'h0, rd_char}, {24'h0, exp});
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_reset = 1'b1; lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
    lcd_data_in = 8'h00; rd_addr = 5'd0;
    repeat (5) @(negedge clk);
    check("reset_outs", {19'h0, lcd_data_oe, lcd_data_out, busy, disp_on, cursor_on, blink_on, cmd_err}, 32'h0);
    check("reset_rd_char", {24'h0, rd_char}, 32'h20);
    reset_reset = 1'b0;
    repeat (5) @(negedge clk);

    // Init sequence and first character
    wr_idle(1'b0, 8'h38);
    wr_idle(1'b0, 8'h0C);
    wr_idle(1'b0, 8'h06);
    wr_idle(1'b1, 8'h41);
    slot(0, 8'h41, "t1_slot0");
    rd(1'b0, 8'h01, "t1_status");
    check("t1_flags", {29'h0, disp_on, cursor_on, blink_on}, 32'h4);
    check("t1_cmd_err", {31'h0, cmd_err}, 32'h0);

    // Line wrap 0x0F -> 0x40
    wr_idle(1'b0, 8'h8F);
    wr_idle(1'b1, 8'h42);
    wr_idle(1'b1, 8'h43);
    slot(15, 8'h42, "t2_slot15");
    slot(16, 8'h43, "t2_slot16");
    rd(1'b0, 8'h41, "t2_status");

    // Write while busy is dropped; status read while busy
    bus_cycle(1'b1, 1'b0, 8'h44);
    bus_cycle(1'b1, 1'b0, 8'h45);
    rd(1'b0, 8'hC2, "t3_status_busy");
    check("t3_cmd_err", {31'h0, cmd_err}, 32'h1);
    wait_idle();
    check("t3_busy_len", busy_len, BUSY_CYCLES);
    slot(17, 8'h44, "t3_slot17");
    slot(18, 8'h20, "t3_slot18_dropped");

    // Fill all slots, then clear display
    wr_idle(1'b0, 8'h80);
    for (int i = 0; i < 32; i++) wr_idle(1'b1, 8'(8'h30 + i));
    slot(0, 8'h30, "t4_fill_slot0");
    slot(31, 8'h4F, "t4_fill_slot31");
    rd(1'b0, 8'h00, "t4_fill_wrap_status");
    wr_idle(1'b0, 8'h01);
    check("t4_clear_busy_len", busy_len, BUSY_LONG_CYCLES);
    for (int i = 0; i < 32; i++) slot(i, 8'h20, $sformatf("t4_clear_slot%0d", i));
    rd(1'b0, 8'h00, "t4_clear_status");

    // Decrement wraps
    wr_idle(1'b0, 8'h04);
    wr_idle(1'b0, 8'hC0);
    wr_idle(1'b1, 8'h58);
    slot(16, 8'h58, "t5_slot16");
    rd(1'b0, 8'h0F, "t5_status_0f");
    wr_idle(1'b0, 8'h80);
    wr_idle(1'b1, 8'h59);
    slot(0, 8'h59, "t5_slot0");
    rd(1'b0, 8'h4F, "t5_status_4f");

    // EN held high across reset commits nothing
    @(negedge clk);
    lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data_in = 8'h5A; lcd_en = 1'b1;
    repeat (6) @(negedge clk);
    reset_reset = 1'b1;
    repeat (3) @(negedge clk);
    reset_reset = 1'b0;
    repeat (6) @(negedge clk);
    lcd_en = 1'b0;
    repeat (8) @(negedge clk);
    slot(0, 8'h20, "t6_slot0_after_reset");
    check("t6_busy_cmd_err", {30'h0, busy, cmd_err}, 32'h0);
    wr_idle(1'b1, 8'h61);
    slot(0, 8'h61, "t6_slot0_write");
    rd(1'b0, 8'h01, "t6_status");

    // Data read steps AC; invalid DDRAM address; shift wraps; no-op
    wr_idle(1'b0, 8'h80);
    rd(1'b1, 8'h61, "t7_data_read");
    rd(1'b0, 8'h01, "t7_status_after_read");
    wr_idle(1'b0, 8'h95);
    check("t7_bad_addr_err", {31'h0, cmd_err}, 32'h1);
    rd(1'b0, 8'h00, "t7_bad_addr_status");
    wr_idle(1'b0, 8'h10);
    rd(1'b0, 8'h4F, "t7_shift_left_wrap");
    wr_idle(1'b0, 8'h14);
    rd(1'b0, 8'h00, "t7_shift_right_wrap");
    wr_idle(1'b0, 8'h0F);
    check("t7_flags_all", {29'h0, disp_on, cursor_on, blink_on}, 32'h7);
    bus_cycle(1'b0, 1'b0, 8'h00);
    check("t7_nop_no_busy", {31'h0, busy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
